// File: rtl/montgomery_param.sv
// Radix-2 Montgomery modular multiplier: result = a*b*2^-WIDTH mod m.
// One multiplication at a time with a start/done handshake, a squaring mode and an even-modulus error.
module montgomery_param #(
    parameter int unsigned WIDTH = 512,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             in_square,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             err,
    output logic             busy
);

    localparam int unsigned CW = WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_SUB  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bad_q, bad_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic [CW-1:0]    t_add;
    logic [CW-1:0]    t_red;
    logic [CW-1:0]    c_diff;

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        bad_d    = bad_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = err_q;
        busy_d   = busy_q;

        // A is consumed LSB-first by shifting, so a_q[0] is always bit i
        t_add  = c_q + (a_q[0] ? CW'(b_q) : CW'(0));
        t_red  = t_add[0] ? (t_add + CW'(m_q)) : t_add;
        c_diff = c_q - CW'(m_q);

        case (state_q)
            S_MULT: begin
                c_d   = t_red >> 1;
                a_d   = a_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                state_d = S_FIN;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                if (bad_q) begin
                    result_d = '0;
                    err_d    = 1'b1;
                end else if (c_q >= CW'(m_q)) begin
                    result_d = c_diff[WIDTH-1:0];
                end else begin
                    result_d = c_q[WIDTH-1:0];
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // FIN drives busy low, so a start there chains straight into the next op
        if ((state_q == S_IDLE || state_q == S_FIN) && start) begin
            a_d     = in_a;
            b_d     = in_square ? in_a : in_b;
            m_d     = in_m;
            c_d     = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            bad_d   = ~in_m[0];
            state_d = in_m[0] ? S_MULT : S_SUB;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            c_q      <= '0;
            cnt_q    <= '0;
            bad_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            bad_q    <= bad_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign err    = err_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_montgomery_param.sv
// Bench for montgomery_param at WIDTH=8 and WIDTH=512 against a modular-arithmetic reference.
module tb_montgomery_param;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic       start8, sq8;
    logic [7:0] a8, b8, m8, result8;
    logic       done8, err8, busy8;

    logic         start512, sq512;
    logic [511:0] a512, b512, m512, result512;
    logic         done512, err512, busy512;

    int checks   = 0;
    int failures = 0;

    montgomery_param #(.WIDTH(8)) dut8 (
        .clk(clk), .resetn(resetn), .start(start8), .in_square(sq8),
        .in_a(a8), .in_b(b8), .in_m(m8),
        .result(result8), .done(done8), .err(err8), .busy(busy8)
    );

    montgomery_param #(.WIDTH(512)) dut512 (
        .clk(clk), .resetn(resetn), .start(start512), .in_square(sq512),
        .in_a(a512), .in_b(b512), .in_m(m512),
        .result(result512), .done(done512), .err(err512), .busy(busy512)
    );

    // a*b mod m, then divided by 2 (mod m) w times
    function automatic logic [511:0] mont_ref(input logic [511:0] a, input logic [511:0] b,
                                              input logic [511:0] m, input int w);
        logic [1025:0] x, mm;
        mm = {514'b0, m};
        x  = ({514'b0, a} * {514'b0, b}) % mm;
        for (int i = 0; i < w; i++) begin
            x = x[0] ? ((x + mm) >> 1) : (x >> 1);
        end
        return x[511:0];
    endfunction

    function automatic logic [7:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        logic [511:0] r;
        r = mont_ref({504'b0, a}, {504'b0, b}, {504'b0, m}, 8);
        return r[7:0];
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Issue one 8-bit op, scramble inputs after the start edge, wait for done
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m, input logic sq,
                       output int lat, output logic [7:0] res, output logic e, output logic bsy);
        @(negedge clk);
        a8 = a; b8 = b; m8 = m; sq8 = sq; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); m8 = 8'($urandom); sq8 = 1'($urandom);
        lat = 1;
        bsy = busy8;
        while (!done8 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        res = result8;
        e   = err8;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        start8 = 1'b0; sq8 = 1'b0; a8 = '0; b8 = '0; m8 = '0;
        start512 = 1'b0; sq512 = 1'b0; a512 = '0; b512 = '0; m512 = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if ({result8, done8, err8, busy8} !== 11'b0) begin
            failures++;
            $display("FAIL reset8 got=%h/%b/%b/%b exp=0/0/0/0", result8, done8, err8, busy8);
        end
        checks++;
        if (result512 !== '0 || done512 !== 1'b0 || err512 !== 1'b0 || busy512 !== 1'b0) begin
            failures++;
            $display("FAIL reset512 got done=%b err=%b busy=%b", done512, err512, busy512);
        end
    endtask

    task automatic test_directed;
        int lat; logic [7:0] res; logic e, bsy;
        logic [7:0] ta [4];
        logic [7:0] tb [4];
        logic       ts [4];
        logic [7:0] tx [4];
        ta[0] = 8'h05; tb[0] = 8'h07; ts[0] = 1'b0; tx[0] = 8'h01;
        ta[1] = 8'h05; tb[1] = 8'hFF; ts[1] = 1'b1; tx[1] = 8'h0A;
        ta[2] = 8'h0C; tb[2] = 8'h0C; ts[2] = 1'b0; tx[2] = 8'h03;
        ta[3] = 8'h00; tb[3] = 8'h07; ts[3] = 1'b0; tx[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            op8(ta[i], tb[i], 8'h0D, ts[i], lat, res, e, bsy);
            checks++;
            if (lat !== 10) begin failures++; $display("FAIL lat8[%0d] got=%0d exp=10", i, lat); end
            checks++;
            if (res !== tx[i]) begin failures++; $display("FAIL res8[%0d] got=%h exp=%h", i, res, tx[i]); end
            checks++;
            if (e !== 1'b0 || bsy !== 1'b1) begin
                failures++; $display("FAIL flags8[%0d] got err=%b busy=%b exp err=0 busy=1", i, e, bsy);
            end
        end
    endtask

    task automatic test_random8;
        int lat; logic [7:0] res, m, a, b, exp; logic e, bsy, sq;
        for (int i = 0; i < 20; i++) begin
            m  = 8'($urandom_range(3, 255)) | 8'h01;
            a  = 8'($urandom_range(0, int'(m) - 1));
            b  = 8'($urandom_range(0, int'(m) - 1));
            sq = 1'($urandom);
            exp = sq ? ref8(a, a, m) : ref8(a, b, m);
            op8(a, b, m, sq, lat, res, e, bsy);
            checks++;
            if (res !== exp || lat !== 10 || e !== 1'b0) begin
                failures++;
                $display("FAIL rand8[%0d] a=%h b=%h m=%h sq=%b got=%h lat=%0d err=%b exp=%h lat=10 err=0",
                         i, a, b, m, sq, res, lat, e, exp);
            end
        end
    endtask

    task automatic test_even_modulus;
        int lat; logic [7:0] res; logic e, bsy;
        op8(8'h05, 8'h07, 8'h0C, 1'b0, lat, res, e, bsy);
        checks++;
        if (lat !== 2 || res !== 8'h00 || e !== 1'b1) begin
            failures++; $display("FAIL even got lat=%0d res=%h err=%b exp lat=2 res=00 err=1", lat, res, e);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err8 !== 1'b1) begin failures++; $display("FAIL err_hold got=%b exp=1", err8); end
        op8(8'h05, 8'h07, 8'h0D, 1'b0, lat, res, e, bsy);
        checks++;
        if (lat !== 10 || res !== 8'h01 || e !== 1'b0) begin
            failures++; $display("FAIL after_even got lat=%0d res=%h err=%b exp lat=10 res=01 err=0", lat, res, e);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, last, n, extra;
        logic [7:0] exp_r [3];
        exp_r[0] = 8'h01; exp_r[1] = 8'h0A; exp_r[2] = 8'h03;
        @(negedge clk);
        m8 = 8'h0D; a8 = 8'h05; b8 = 8'h07; sq8 = 1'b0; start8 = 1'b1;
        cyc = 0; last = 0; n = 0;
        while (n < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done8) begin
                checks++;
                if (result8 !== exp_r[n] || (cyc - last) !== 10) begin
                    failures++;
                    $display("FAIL b2b[%0d] got res=%h gap=%0d exp res=%h gap=10", n, result8, cyc - last, exp_r[n]);
                end
                last = cyc;
                n++;
                if (n == 1) begin a8 = 8'h05; b8 = 8'hFF; sq8 = 1'b1; end
                if (n == 2) begin a8 = 8'h0C; b8 = 8'h0C; sq8 = 1'b0; end
                if (n == 3) start8 = 1'b0;
            end
        end
        checks++;
        if (n !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", n); end
        start8 = 1'b0;
        // Start pulses while busy must be dropped
        @(negedge clk);
        a8 = 8'h0C; b8 = 8'h0C; m8 = 8'h0D; sq8 = 1'b0; start8 = 1'b1;
        extra = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start8 = (c == 3 || c == 6);
            if (c == 3) begin a8 = 8'h01; m8 = 8'h0C; end
            if (done8) extra++;
        end
        checks++;
        if (extra !== 1 || result8 !== 8'h03 || err8 !== 1'b0) begin
            failures++; $display("FAIL busy_ignore got dones=%0d res=%h err=%b exp dones=1 res=03 err=0", extra, result8, err8);
        end
        start8 = 1'b0;
    endtask

    task automatic test_reset_mid;
        int lat, dn; logic [7:0] res; logic e, bsy;
        @(negedge clk);
        a8 = 8'h05; b8 = 8'h07; m8 = 8'h0D; sq8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if ({result8, done8, err8, busy8} !== 11'b0) begin
            failures++; $display("FAIL mid_reset got=%h/%b/%b/%b exp=0/0/0/0", result8, done8, err8, busy8);
        end
        @(negedge clk);
        resetn = 1'b1;
        dn = 0;
        repeat (15) begin @(negedge clk); if (done8) dn++; end
        checks++;
        if (dn !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", dn); end
        op8(8'h05, 8'h07, 8'h0D, 1'b0, lat, res, e, bsy);
        checks++;
        if (lat !== 10 || res !== 8'h01) begin
            failures++; $display("FAIL post_reset got lat=%0d res=%h exp lat=10 res=01", lat, res);
        end
    endtask

    task automatic test_wide;
        logic [511:0] a, b, m, exp;
        int lat;
        for (int i = 0; i < 3; i++) begin
            m = rand512() | {1'b1, 510'b0, 1'b1};
            a = rand512() % m;
            b = rand512() % m;
            exp = mont_ref(a, b, m, 512);
            @(negedge clk);
            a512 = a; b512 = b; m512 = m; sq512 = 1'b0; start512 = 1'b1;
            @(negedge clk);
            start512 = 1'b0;
            a512 = rand512(); b512 = rand512(); m512 = rand512();
            lat = 1;
            while (!done512 && lat < 600) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat !== 514) begin failures++; $display("FAIL lat512[%0d] got=%0d exp=514", i, lat); end
            checks++;
            if (result512 !== exp || err512 !== 1'b0) begin
                failures++;
                $display("FAIL res512[%0d] got=%h exp=%h err=%b", i, result512[63:0], exp[63:0], err512);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random8();
        test_even_modulus();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
